// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: program-memory read port plus the valid/ready word channel
// toward the decoder. master = fetch sequencer, slave = memory/decoder side.
interface instr_fetch_if #(
    parameter int ADDRESS_BITS = 5,
    parameter int INSTR_BITS   = 3
);
    localparam int VALUE_BITS = INSTR_BITS + ADDRESS_BITS;

    logic [ADDRESS_BITS-1:0] o_mem_addr;
    logic                    o_mem_rd;
    logic [VALUE_BITS-1:0]   i_mem_rdata;
    logic [VALUE_BITS-1:0]   o_value;
    logic                    o_valid;
    logic                    i_ready;

    modport master (
        output o_mem_addr,
        output o_mem_rd,
        input  i_mem_rdata,
        output o_value,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_mem_addr,
        input  o_mem_rd,
        output i_mem_rdata,
        input  o_value,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch sequencer: walks PC through program memory and hands legal words to the decoder.
// Optional macro INSTR_FETCH_PC_WRAP_EN: PC wraps to 0 after the last word instead of ending.
module instr_fetch #(
    parameter int ADDRESS_BITS = 5,
    parameter int INSTR_BITS   = 3,
    parameter int PROG_DEPTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_halt,
    instr_fetch_if.master         bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [ADDRESS_BITS:0] o_count
);
    localparam int VALUE_BITS = INSTR_BITS + ADDRESS_BITS;
    localparam logic [ADDRESS_BITS-1:0] LAST_PC = ADDRESS_BITS'(PROG_DEPTH - 1);

`ifdef INSTR_FETCH_PC_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PRESENT,
        HALTED
    } state_t;

    state_t                  state;
    logic [ADDRESS_BITS-1:0] pc;
    logic [INSTR_BITS-1:0]   opcode;
    logic                    at_end;
    logic [ADDRESS_BITS-1:0] pc_adv;

    function automatic logic is_halt(input logic [INSTR_BITS-1:0] op);
        return op == '0;
    endfunction

    function automatic logic is_legal(input logic [INSTR_BITS-1:0] op);
        return (op == INSTR_BITS'(1)) || (op == INSTR_BITS'(2)) || (op == INSTR_BITS'(4));
    endfunction

    function automatic logic [ADDRESS_BITS:0] sat_inc(input logic [ADDRESS_BITS:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign opcode         = bus.i_mem_rdata[VALUE_BITS-1:ADDRESS_BITS];
    assign at_end         = (pc == LAST_PC) && !WRAP_EN;
    assign pc_adv         = (pc == LAST_PC) ? '0 : pc + 1'b1;
    assign bus.o_mem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= '0;
            bus.o_value  <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_mem_rd <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_count      <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    // start beats a simultaneous halt while idle
                    if (i_start) begin
                        pc           <= '0;
                        o_count      <= '0;
                        o_done       <= 1'b0;
                        o_err        <= 1'b0;
                        bus.o_mem_rd <= 1'b1;
                        o_busy       <= 1'b1;
                        state        <= FETCH;
                    end
                end

                FETCH: begin
                    bus.o_mem_rd <= 1'b0;
                    if (i_halt) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= HALTED;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (i_halt || is_halt(opcode)) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= HALTED;
                    end else if (!is_legal(opcode)) begin
                        // illegal word is flagged and skipped, never presented
                        o_err <= 1'b1;
                        if (at_end) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= HALTED;
                        end else begin
                            pc           <= pc_adv;
                            bus.o_mem_rd <= 1'b1;
                            state        <= FETCH;
                        end
                    end else begin
                        bus.o_value <= bus.i_mem_rdata;
                        bus.o_valid <= 1'b1;
                        state       <= PRESENT;
                    end
                end

                PRESENT: begin
                    // a transfer on the halt cycle still counts
                    if (bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                        o_count     <= sat_inc(o_count);
                    end
                    if (i_halt) begin
                        bus.o_valid <= 1'b0;
                        o_done      <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= HALTED;
                    end else if (bus.i_ready) begin
                        if (at_end) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= HALTED;
                        end else begin
                            pc           <= pc_adv;
                            bus.o_mem_rd <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end

                default: begin
                    bus.o_valid  <= 1'b0;
                    bus.o_mem_rd <= 1'b0;
                    o_busy       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed programs, expected words queued at
// issue time and popped by an independent monitor on every decoder transfer.
module tb_instr_fetch;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic       i_halt;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [5:0] o_count;

    logic [7:0] mem [32];
    logic [7:0] sb [$];
    int         errors = 0;
    int         checks = 0;

    instr_fetch_if #(.ADDRESS_BITS(5), .INSTR_BITS(3)) bus ();

    instr_fetch #(.ADDRESS_BITS(5), .INSTR_BITS(3), .PROG_DEPTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_halt  (i_halt),
        .bus     (bus),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    // program memory: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.o_mem_rd) bus.i_mem_rdata <= mem[bus.o_mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: pop on transfer, otherwise the held word must match the head
    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {24'd0, bus.o_value}, 32'hFFFF_FFFF);
            end else if (bus.i_ready) begin
                check("xfer_value", {24'd0, bus.o_value}, {24'd0, sb.pop_front()});
            end else begin
                check("held_value", {24'd0, bus.o_value}, {24'd0, sb[0]});
            end
        end
    end

`ifdef INSTR_FETCH_PC_WRAP_EN
    logic       wrapped = 1'b0;
    logic [4:0] prev_addr = '0;
    always @(posedge clk) begin
        if (bus.o_mem_rd) begin
            if (prev_addr == 5'd31 && bus.o_mem_addr == 5'd0) wrapped <= 1'b1;
            prev_addr <= bus.o_mem_addr;
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_prog();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    task automatic wait_done(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (o_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.o_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        i_start         = 1'b0;
        i_halt          = 1'b0;
        bus.i_ready     = 1'b1;
        bus.i_mem_rdata = '0;
        clear_mem();
        repeat (3) tick();
        check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_mem_rd", {31'd0, bus.o_mem_rd}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_count", {26'd0, o_count}, 32'd0);
        check("rst_value", {24'd0, bus.o_value}, 32'd0);
        check("rst_addr", {27'd0, bus.o_mem_addr}, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic program with latency checks
        mem[0] = 8'h21; mem[1] = 8'h43; mem[2] = 8'h85; mem[3] = 8'h00;
        sb.push_back(8'h21); sb.push_back(8'h43); sb.push_back(8'h85);
        start_prog();
        check("lat_mem_rd", {31'd0, bus.o_mem_rd}, 32'd1);
        check("lat_busy", {31'd0, o_busy}, 32'd1);
        check("lat_addr", {27'd0, bus.o_mem_addr}, 32'd0);
        tick();
        check("lat_mem_rd_low", {31'd0, bus.o_mem_rd}, 32'd0);
        check("lat_no_valid", {31'd0, bus.o_valid}, 32'd0);
        tick();
        check("lat_valid", {31'd0, bus.o_valid}, 32'd1);
        wait_done("a_done_timeout");
        check("a_count", {26'd0, o_count}, 32'd3);
        check("a_err", {31'd0, o_err}, 32'd0);
        check("a_busy", {31'd0, o_busy}, 32'd0);
        check("a_sb_empty", sb.size(), 32'd0);

        // illegal opcode skipped
        clear_mem();
        mem[0] = 8'h21; mem[1] = 8'h62; mem[2] = 8'h41; mem[3] = 8'h00;
        sb.push_back(8'h21); sb.push_back(8'h41);
        start_prog();
        check("b_done_cleared", {31'd0, o_done}, 32'd0);
        check("b_count_cleared", {26'd0, o_count}, 32'd0);
        wait_done("b_done_timeout");
        check("b_err", {31'd0, o_err}, 32'd1);
        check("b_count", {26'd0, o_count}, 32'd2);
        check("b_sb_empty", sb.size(), 32'd0);

        // back-pressure: word held for 5 cycles
        clear_mem();
        mem[0] = 8'h43; mem[1] = 8'h00;
        sb.push_back(8'h43);
        bus.i_ready = 1'b0;
        start_prog();
        check("c_err_cleared", {31'd0, o_err}, 32'd0);
        wait_valid("c_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("c_hold_valid", {31'd0, bus.o_valid}, 32'd1);
            check("c_hold_value", {24'd0, bus.o_value}, 32'h43);
            check("c_hold_count", {26'd0, o_count}, 32'd0);
        end
        bus.i_ready = 1'b1;
        tick();
        check("c_count_once", {26'd0, o_count}, 32'd1);
        check("c_valid_drop", {31'd0, bus.o_valid}, 32'd0);
        wait_done("c_done_timeout");
        check("c_count_final", {26'd0, o_count}, 32'd1);

        // reset mid-PRESENT
        bus.i_ready = 1'b0;
        start_prog();
        wait_valid("r_valid_timeout");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        check("r_valid", {31'd0, bus.o_valid}, 32'd0);
        check("r_busy", {31'd0, o_busy}, 32'd0);
        check("r_count", {26'd0, o_count}, 32'd0);
        check("r_addr", {27'd0, bus.o_mem_addr}, 32'd0);
        check("r_value", {24'd0, bus.o_value}, 32'd0);
        bus.i_ready = 1'b1;
        tick();
        check("r_idle_stays", {31'd0, o_busy}, 32'd0);

        // halt on the same cycle as the 0x85 transfer
        clear_mem();
        mem[0] = 8'h21; mem[1] = 8'h43; mem[2] = 8'h85; mem[3] = 8'h21; mem[4] = 8'h00;
        sb.push_back(8'h21); sb.push_back(8'h43); sb.push_back(8'h85);
        start_prog();
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (bus.o_valid && bus.o_value == 8'h85) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            check("d_see_85", {31'd0, seen}, 32'd1);
        end
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        check("d_count", {26'd0, o_count}, 32'd3);
        check("d_valid", {31'd0, bus.o_valid}, 32'd0);
        check("d_done", {31'd0, o_done}, 32'd1);
        check("d_busy", {31'd0, o_busy}, 32'd0);
        check("d_sb_empty", sb.size(), 32'd0);
        repeat (3) tick();
        check("d_stays_halted", {31'd0, o_busy}, 32'd0);

        // restart with start and halt together: start wins
        sb.push_back(8'h21); sb.push_back(8'h43); sb.push_back(8'h85); sb.push_back(8'h21);
        i_halt = 1'b1;
        start_prog();
        i_halt = 1'b0;
        check("e_busy", {31'd0, o_busy}, 32'd1);
        check("e_done_cleared", {31'd0, o_done}, 32'd0);
        check("e_count_cleared", {26'd0, o_count}, 32'd0);
        check("e_addr", {27'd0, bus.o_mem_addr}, 32'd0);
        wait_done("e_done_timeout");
        check("e_count", {26'd0, o_count}, 32'd4);

        // all 32 words legal, no HALT word
        for (int i = 0; i < 32; i++) mem[i] = 8'h21;
`ifdef INSTR_FETCH_PC_WRAP_EN
        for (int i = 0; i < 40; i++) sb.push_back(8'h21);
        start_prog();
        begin
            logic hit = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (o_count == 6'd40) begin
                    hit = 1'b1;
                    break;
                end
                tick();
            end
            check("w_count_timeout", {31'd0, hit}, 32'd1);
        end
        check("w_wrapped", {31'd0, wrapped}, 32'd1);
        check("w_not_done", {31'd0, o_done}, 32'd0);
        i_halt = 1'b1;
        tick();
        i_halt = 1'b0;
        check("w_halt_done", {31'd0, o_done}, 32'd1);
        check("w_count", {26'd0, o_count}, 32'd40);
`else
        for (int i = 0; i < 32; i++) sb.push_back(8'h21);
        start_prog();
        wait_done("f_done_timeout");
        check("f_count", {26'd0, o_count}, 32'd32);
        check("f_err", {31'd0, o_err}, 32'd0);
        check("f_addr_last", {27'd0, bus.o_mem_addr}, 32'd31);
`endif
        check("end_sb_empty", sb.size(), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
